// File: rtl/regfile_burst_master_pkg.sv
// Shared defaults and FSM state encoding for the register-file burst master.
package regfile_burst_master_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrite  = 3'd1,
        StWdrain = 3'd2,
        StRead   = 3'd3,
        StDone   = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_burst_master_if.sv
// Command, write-stream, read-stream and register-file pin bundle of the burst master.
interface regfile_burst_master_if
    import regfile_burst_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len_m1;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len_m1, wr_valid, wr_data, rd_ready, rf_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, busy, rf_addr, rf_wdata, rf_we
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len_m1, wr_valid, wr_data, rd_ready, rf_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, busy, rf_addr, rf_wdata, rf_we
    );

endinterface

// File: rtl/regfile_burst_master_rf_rd_buffer.sv
// Two-entry synchronous FIFO holding read beats returned by the register file.
module regfile_burst_master_rf_rd_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    // A push into a full buffer is only legal when the same cycle frees a slot.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_burst_master.sv
// Burst initiator driving a single-port register file: write bursts from a stream,
// read bursts into a stream through a 2-entry credit-limited buffer.
module regfile_burst_master
    import regfile_burst_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic                    clk,
    input logic                    rst,
    regfile_burst_master_if.master bus
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] beats_left_q;
    logic [ADDR_WIDTH:0]   issue_left_q;
    logic                  in_flight_q;
    logic                  rf_we_q;

    logic                  wr_hs;
    logic                  pop;
    logic                  issue;
    logic [2:0]            used;
    logic                  buf_full;
    logic                  buf_empty;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_data;

    assign wr_hs = (state_q == StWrite) && bus.wr_valid;
    assign pop   = !buf_empty && bus.rd_ready;
    // Slots committed after this cycle's pop; a same-cycle pop frees credit for full throughput.
    assign used  = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue = (state_q == StRead) && (issue_left_q != '0) && (used < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            issue_left_q <= '0;
            in_flight_q  <= 1'b0;
            rf_we_q      <= 1'b0;
        end else begin
            in_flight_q <= issue;
            rf_we_q     <= wr_hs;
            case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        cur_addr_q   <= bus.cmd_addr;
                        beats_left_q <= bus.cmd_len_m1;
                        issue_left_q <= {1'b0, bus.cmd_len_m1} + (ADDR_WIDTH + 1)'(1);
                        state_q      <= bus.cmd_write ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (wr_hs) begin
                        cur_addr_q   <= cur_addr_q + ADDR_WIDTH'(1);
                        beats_left_q <= beats_left_q - ADDR_WIDTH'(1);
                        if (beats_left_q == '0) begin
                            state_q <= StWdrain;
                        end
                    end
                end
                StWdrain: state_q <= StIdle;
                StRead: begin
                    if (issue) begin
                        cur_addr_q   <= cur_addr_q + ADDR_WIDTH'(1);
                        issue_left_q <= issue_left_q - (ADDR_WIDTH + 1)'(1);
                    end
                    if (pop) begin
                        beats_left_q <= beats_left_q - ADDR_WIDTH'(1);
                        if (beats_left_q == '0) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    regfile_burst_master_rf_rd_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (bus.rf_rdata),
        .pop       (pop),
        .pop_data  (buf_data),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // The credit check must never let a returning beat meet a full, non-draining buffer.
    assert property (@(posedge clk) disable iff (rst) !(in_flight_q && buf_full && !pop));

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.wr_ready  = (state_q == StWrite);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StWdrain) || (state_q == StDone);
    assign bus.rf_addr   = cur_addr_q;
    assign bus.rf_wdata  = bus.wr_data;
    assign bus.rf_we     = rf_we_q;
    assign bus.rd_valid  = !buf_empty;
    assign bus.rd_data   = buf_data;

endmodule

// File: tb/tb_regfile_burst_master.sv
// Directed and randomized bursts against a register-file pin model and a reference memory.
module tb_regfile_burst_master;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_burst_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: address/data captured at an edge, committed at the next edge if rf_we.
    logic [DW-1:0] rf_mem [DEPTH];
    logic [AW-1:0] rf_a = '0;
    logic [DW-1:0] rf_d = '0;
    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) rf_mem[rf_a] <= rf_d;
        rf_a <= bus.rf_addr;
        rf_d <= bus.rf_wdata;
    end
    assign bus.rf_rdata = rf_mem[rf_a];

    logic [DW-1:0] ref_mem [DEPTH];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = w;
        bus.cmd_addr   = a;
        bus.cmd_len_m1 = l;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'($urandom);
        bus.cmd_addr   = AW'($urandom);
        bus.cmd_len_m1 = AW'($urandom);
        check("busy_after_cmd", 64'(bus.busy), 64'd1);
        check("cmd_ready_in_burst", 64'(bus.cmd_ready), 64'd0);
    endtask

    // mode: 0 = wr_valid always, 1 = idle every other cycle, 2 = random
    task automatic write_burst(input logic [AW-1:0] a, input int l, input int mode,
                               input logic [DW-1:0] data[$]);
        int   hs   = 0;
        int   cyc  = 0;
        logic prev = 1'b0;
        logic v;
        do_cmd(1'b1, a, AW'(l));
        while (hs <= l && cyc < 400) begin
            check("wr_ready", 64'(bus.wr_ready), 64'd1);
            check("wr_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
            check("wr_rf_we", 64'(bus.rf_we), 64'(prev));
            check("wr_rf_addr", 64'(bus.rf_addr), 64'(AW'(a + AW'(hs))));
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = 1'($urandom);
            endcase
            bus.wr_valid = v;
            bus.wr_data  = v ? data[hs] : DW'($urandom);
            prev = v;
            if (v) begin
                ref_mem[AW'(a + AW'(hs))] = data[hs];
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        check("wr_beats_accepted", 64'(hs), 64'(l + 1));
        check("wdrain_done", 64'(bus.done), 64'd1);
        check("wdrain_rf_we", 64'(bus.rf_we), 64'd1);
        check("wdrain_wr_ready", 64'(bus.wr_ready), 64'd0);
        @(negedge clk);
        check("wr_done_pulse_end", 64'(bus.done), 64'd0);
        check("wr_idle_rf_we", 64'(bus.rf_we), 64'd0);
        check("wr_idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        for (int i = 0; i <= l; i++) begin
            check("wr_mem", 64'(rf_mem[AW'(a + AW'(i))]), 64'(ref_mem[AW'(a + AW'(i))]));
        end
    endtask

    // mode: 0 = rd_ready always, 1 = 1,0,0 repeating, 2 = random; abort_after > 0 resets mid-burst
    task automatic read_burst(input logic [AW-1:0] a, input int l, input int mode,
                              input int abort_after);
        int            pops  = 0;
        int            cyc   = 1;
        int            first = -1;
        int            last  = -1;
        int            issued;
        logic          r;
        logic          hold;
        logic [AW-1:0] prev_addr;
        do_cmd(1'b0, a, AW'(l));
        while (pops <= l && cyc < 400) begin
            issued = int'(AW'(bus.rf_addr - a));
            check("rd_outstanding_le2", 64'(issued - pops <= 2), 64'd1);
            check("rd_issue_bound", 64'(issued <= l + 1), 64'd1);
            check("rd_rf_we_low", 64'(bus.rf_we), 64'd0);
            check("rd_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
            if (abort_after != 0 && pops == abort_after) begin
                check("pre_reset_rd_valid", 64'(bus.rd_valid), 64'd1);
                #2 rst = 1'b1;
                #1;
                check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
                check("rst_rd_data", 64'(bus.rd_data), 64'd0);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_rf_we", 64'(bus.rf_we), 64'd0);
                check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
                check("rst_done", 64'(bus.done), 64'd0);
                check("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                bus.rd_ready = 1'b0;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom);
            endcase
            bus.rd_ready = r;
            bus.wr_valid = (mode == 2) ? 1'($urandom) : 1'b0;
            if (mode == 0 && cyc == 2) check("rd_latency_early", 64'(bus.rd_valid), 64'd0);
            if (bus.rd_valid === 1'b1 && r) begin
                check("rd_data", 64'(bus.rd_data), 64'(ref_mem[AW'(a + AW'(pops))]));
                if (first < 0) first = cyc;
                last = cyc;
                pops++;
            end
            hold      = (issued - pops == 2) && !(bus.rd_valid === 1'b1 && r);
            prev_addr = bus.rf_addr;
            @(negedge clk);
            cyc++;
            if (hold) check("rd_addr_stall", 64'(bus.rf_addr), 64'(prev_addr));
        end
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        check("rd_beats_popped", 64'(pops), 64'(l + 1));
        if (mode == 0) begin
            check("rd_first_beat_cycle", 64'(first), 64'd3);
            check("rd_back_to_back", 64'(last - first), 64'(l));
        end
        check("rd_done", 64'(bus.done), 64'd1);
        check("rd_done_rd_valid", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        check("rd_done_pulse_end", 64'(bus.done), 64'd0);
        check("rd_idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rd_idle_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [AW-1:0] ra;
        int            rl;

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len_m1 = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("reset_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_rf_we", 64'(bus.rf_we), 64'd0);
        check("reset_rf_addr", 64'(bus.rf_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-depth write initialises every register.
        q = {};
        for (int i = 0; i < int'(DEPTH); i++) q.push_back(DW'($urandom));
        write_burst(AW'(0), int'(DEPTH) - 1, 0, q);

        q = {32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        write_burst(AW'(4), 3, 0, q);
        read_burst(AW'(4), 3, 0, 0);
        read_burst(AW'(0), 7, 1, 0);

        q = {32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(AW'(30), 3, 0, q);
        check("wrap_reg31", 64'(rf_mem[31]), 64'd2);
        check("wrap_reg0", 64'(rf_mem[0]), 64'd3);
        read_burst(AW'(30), 3, 0, 0);

        // Gapped write followed immediately by a read of the same range.
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(DW'($urandom));
        write_burst(AW'(12), 5, 1, q);
        read_burst(AW'(12), 5, 0, 0);

        for (int k = 0; k < 8; k++) begin
            ra = AW'($urandom);
            rl = int'($urandom_range(0, 9));
            q  = {};
            for (int i = 0; i <= rl; i++) q.push_back(DW'($urandom));
            write_burst(ra, rl, 2, q);
            read_burst(AW'($urandom), int'($urandom_range(0, 9)), 2, 0);
        end

        read_burst(AW'(8), 5, 0, 2);
        read_burst(AW'(4), 3, 0, 0);
        read_burst(AW'(31), 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
